// File: rtl/mlp_seq_net.sv
// mlp_seq_net: two-layer fixed-point perceptron built around a single shared
// multiply-accumulate datapath. N_IN inputs, N_HID hidden neurons, one output.
// Weights and biases live in a run-time writable register file.
// Optional build macro MLP_LEAKY_RELU_EN: hidden layer uses leaky ReLU
// (negative pre-activation >>> 3) instead of plain ReLU.
module mlp_seq_net #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int N_IN       = 2,
  parameter int N_HID      = 4,
  localparam int DEPTH     = N_HID*(N_IN+1) + N_HID + 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       En,
  input  logic                       Run,
  input  logic [N_IN*DATA_WIDTH-1:0] X,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic [DATA_WIDTH-1:0]      Y,
  output logic                       Busy,
  output logic                       Done,
  output logic [1:0]                 Ready_Bus
);

  localparam int DW    = DATA_WIDTH;
  localparam int NMAX  = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int ACC_W = DW + FRAC_BITS + $clog2(NMAX+1) + 1;
  localparam int SW    = ACC_W + 1;
  localparam int PW    = 2*DW;
  localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int HW    = (N_HID > 1) ? $clog2(N_HID) : 1;

  // Saturation limits in the pre-activation width.
  localparam logic signed [SW-1:0] MAX_S = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S = ~MAX_S;

  typedef enum logic [2:0] {
    S_IDLE, S_L1_MAC, S_L1_ACT, S_L2_MAC, S_L2_ACT, S_DONE
  } state_t;

  state_t                   state, state_nx;
  logic [DEPTH-1:0][DW-1:0] rf;
  logic [N_IN-1:0][DW-1:0]  x_q;
  logic [N_HID-1:0][DW-1:0] hid;
  logic [AW-1:0]            ptr;
  logic [IW-1:0]            i_cnt;
  logic [HW-1:0]            h_cnt;
  logic signed [ACC_W-1:0]  acc;

  logic signed [DW-1:0]     op_a, op_w;
  logic signed [PW-1:0]     prod, prod_sh;
  logic signed [ACC_W-1:0]  mac;
  logic signed [SW-1:0]     pre;
  logic [DW-1:0]            hid_act, out_sat;
  logic                     i_last, h_last;

  function automatic logic [DW-1:0] sat_s(input logic signed [SW-1:0] v);
    if (v > MAX_S)      return MAX_S[DW-1:0];
    else if (v < MIN_S) return MIN_S[DW-1:0];
    else                return v[DW-1:0];
  endfunction

  assign i_last = (i_cnt == IW'(N_IN-1));
  assign h_last = (h_cnt == HW'(N_HID-1));

  // Shared MAC/activation datapath. The register file is walked strictly in
  // address order over a run, so one pointer addresses weights and biases.
  always_comb begin
    op_a    = (state == S_L1_MAC) ? x_q[i_cnt] : hid[h_cnt];
    op_w    = rf[ptr];
    prod    = PW'(op_a) * PW'(op_w);
    prod_sh = prod >>> FRAC_BITS;
    mac     = acc + ACC_W'(prod_sh);
    pre     = SW'(acc) + SW'(op_w);
    out_sat = sat_s(pre);
`ifdef MLP_LEAKY_RELU_EN
    hid_act = (pre < 0) ? sat_s(pre >>> 3) : sat_s(pre);
`else
    hid_act = (pre < 0) ? '0 : sat_s(pre);
`endif
  end

  // State register; En low freezes the sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    state <= S_IDLE;
    else if (En) state <= state_nx;
  end

  // Next-state: layer 1 loops MAC/ACT per hidden neuron, then layer 2.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (Run) state_nx = S_L1_MAC;
      S_L1_MAC: if (i_last) state_nx = S_L1_ACT;
      S_L1_ACT: state_nx = h_last ? S_L2_MAC : S_L1_MAC;
      S_L2_MAC: if (h_last) state_nx = S_L2_ACT;
      S_L2_ACT: state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Datapath registers and status outputs, all gated by En.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q       <= '0;
      hid       <= '0;
      acc       <= '0;
      ptr       <= '0;
      i_cnt     <= '0;
      h_cnt     <= '0;
      Y         <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Ready_Bus <= 2'b00;
    end else if (En) begin
      Done <= (state == S_L2_ACT);
      case (state)
        S_IDLE: if (Run) begin
          x_q       <= X;
          acc       <= '0;
          ptr       <= '0;
          i_cnt     <= '0;
          h_cnt     <= '0;
          Busy      <= 1'b1;
          Ready_Bus <= 2'b00;
        end
        S_L1_MAC: begin
          acc   <= mac;
          ptr   <= ptr + AW'(1);
          i_cnt <= i_last ? '0 : i_cnt + IW'(1);
        end
        S_L1_ACT: begin
          hid[h_cnt] <= hid_act;
          acc        <= '0;
          ptr        <= ptr + AW'(1);
          h_cnt      <= h_last ? '0 : h_cnt + HW'(1);
          if (h_last) Ready_Bus[0] <= 1'b1;
        end
        S_L2_MAC: begin
          acc   <= mac;
          ptr   <= ptr + AW'(1);
          h_cnt <= h_last ? '0 : h_cnt + HW'(1);
        end
        S_L2_ACT: begin
          Y            <= out_sat;
          Busy         <= 1'b0;
          Ready_Bus[1] <= 1'b1;
          acc          <= '0;
          ptr          <= '0;
        end
        default: ;
      endcase
    end
  end

  // Parameter file: writable whenever no run is in flight, independent of En.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rf <= '0;
    else if (wr_en && !Busy && ({1'b0, wr_addr} < (AW+1)'(DEPTH)))
      rf[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_mlp_seq_net.sv
// Directed bench for mlp_seq_net with an integer reference model of the net.
module tb_mlp_seq_net;

  localparam int NI = 2;
  localparam int NH = 4;
  localparam int DEPTH = NH*(NI+1) + NH + 1;
  localparam int B = NH*(NI+1);
  localparam int NOLIT = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        En = 1'b1;
  logic        Run = 1'b0;
  logic [15:0] X = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  Y;
  logic        Busy, Done;
  logic [1:0]  Ready_Bus;

  int total = 0;
  int bad = 0;
  int wm[DEPTH];
  int exp_y = 0;
  int done_cnt = 0;
  int cyc = 0;
  int dc[$];

  mlp_seq_net dut (
    .clk(clk), .rst(rst), .En(En), .Run(Run), .X(X),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .Y(Y), .Busy(Busy), .Done(Done), .Ready_Bus(Ready_Bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int fdiv(input int p, input int d);
    if (p >= 0) return p / d;
    return -((-p + d - 1) / d);
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference network: floor-scaled products, per-neuron bias, activation.
  function automatic int model(input int a0, input int a1);
    int xs[NI];
    int hv[NH];
    int s;
    xs[0] = a0;
    xs[1] = a1;
    for (int h = 0; h < NH; h++) begin
      s = wm[h*(NI+1)+NI];
      for (int i = 0; i < NI; i++) s += fdiv(xs[i] * wm[h*(NI+1)+i], 16);
`ifdef MLP_LEAKY_RELU_EN
      if (s < 0) s = fdiv(s, 8);
      hv[h] = clamp(s, -128, 127);
`else
      hv[h] = clamp(s, 0, 127);
`endif
    end
    s = wm[B+NH];
    for (int h = 0; h < NH; h++) s += fdiv(hv[h] * wm[B+h], 16);
    return clamp(s, -128, 127);
  endfunction

  // Compare process: every Done rising edge checks Y against the model.
  initial begin
    logic done_q;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && Done && !done_q) begin
        done_cnt++;
        dc.push_back(cyc);
        chk("y_model", int'($signed(Y)), exp_y);
        chk("ready_at_done", int'(Ready_Bus), 3);
        chk("busy_at_done", int'(Busy), 0);
      end
      done_q = Done;
    end
  end

  task automatic wr(input int a, input int d, input bit upd);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 5'(a);
    wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
    if (upd) wm[a] = d;
  endtask

  task automatic clear_all();
    for (int a = 0; a < DEPTH; a++) wr(a, 0, 1'b1);
  endtask

  task automatic load_xor();
    clear_all();
    wr(0, 16, 1'b1); wr(1, 16, 1'b1);
    wr(3, 16, 1'b1); wr(4, 16, 1'b1); wr(5, -16, 1'b1);
    wr(B, 16, 1'b1); wr(B+1, -32, 1'b1);
  endtask

  // One run: optional write alongside Run, optional En stall, optional
  // write attempt while busy (must be ignored, so the model is not updated).
  task automatic do_run(input int x0, input int x1, input int lit,
                        input int cw_a, input int cw_d,
                        input int stall_at, input int stall_len, input int prot_at);
    int cnt;
    bit seen;
    @(negedge clk);
    X = {8'(x1), 8'(x0)};
    Run = 1'b1;
    if (cw_a >= 0) begin
      wr_en = 1'b1; wr_addr = 5'(cw_a); wr_data = 8'(cw_d);
      wm[cw_a] = cw_d;
    end
    exp_y = model(x0, x1);
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    Run = 1'b0;
    wr_en = 1'b0;
    seen = 1'b0;
    while (!seen && cnt < 100) begin
      if (Done) seen = 1'b1;
      else begin
        if (stall_len == 0 && cnt == 2) begin
          chk("busy_mid_run", int'(Busy), 1);
          chk("ready_cleared", int'(Ready_Bus), 0);
        end
        if (stall_len == 0 && cnt == 14) chk("ready_l1", int'(Ready_Bus), 1);
        En = !(stall_len > 0 && cnt >= stall_at && cnt < stall_at + stall_len);
        wr_en = (cnt == prot_at);
        wr_addr = '0;
        wr_data = '0;
        @(posedge clk);
        cnt++;
        @(negedge clk);
      end
    end
    En = 1'b1;
    wr_en = 1'b0;
    chk("done_seen", int'(seen), 1);
    chk("latency", cnt, 18 + stall_len);
    if (lit != NOLIT) chk("y_literal", int'($signed(Y)), lit);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, k, leaky_lit;
    for (int a = 0; a < DEPTH; a++) wm[a] = 0;

    repeat (3) @(negedge clk);
    chk("rst_y", int'(Y), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_ready", int'(Ready_Bus), 0);
    rst = 1'b1;

    // XOR truth table
    load_xor();
    wr(31, 99, 1'b0);
    do_run(0, 0, 0, -1, 0, -1, 0, -1);
    do_run(16, 0, 16, -1, 0, -1, 0, -1);
    do_run(0, 16, 16, -1, 0, -1, 0, -1);
    do_run(16, 16, 0, -1, 0, -1, 0, -1);

    // Write in the Run-accept cycle is used by that run
    do_run(16, 16, 8, B+NH, 8, -1, 0, -1);
    wr(B+NH, 0, 1'b1);

    // En stall mid layer 1
    do_run(16, 0, 16, -1, 0, 4, 5, -1);

    // Write to address 0 while busy must not land
    do_run(0, 16, 16, -1, 0, -1, 0, 3);
    do_run(16, 0, 16, -1, 0, -1, 0, -1);

    // Run held high: back-to-back runs 19 cycles apart
    @(negedge clk);
    X = {8'd0, 8'd16};
    exp_y = model(16, 0);
    n0 = done_cnt;
    dc.delete();
    Run = 1'b1;
    k = 0;
    while (done_cnt < n0 + 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    Run = 1'b0;
    chk("b2b_runs", done_cnt - n0, 3);
    if (dc.size() >= 3) begin
      chk("b2b_gap1", dc[1] - dc[0], 19);
      chk("b2b_gap2", dc[2] - dc[1], 19);
    end

    // Reset mid-run aborts without Done
    @(negedge clk);
    @(negedge clk);
    X = {8'd16, 8'd16};
    Run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Run = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_y", int'(Y), 0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_ready", int'(Ready_Bus), 0);
    chk("abort_done", int'(Done), 0);
    n0 = done_cnt;
    for (int a = 0; a < DEPTH; a++) wm[a] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt, n0);
    chk("abort_idle_busy", int'(Busy), 0);

    // Rerun after reload
    load_xor();
    do_run(16, 16, 0, -1, 0, -1, 0, -1);
    do_run(0, 16, 16, -1, 0, -1, 0, -1);

    // Saturation, positive then negative
    clear_all();
    for (int h = 0; h < NH; h++) begin
      wr(h*(NI+1), 127, 1'b1);
      wr(h*(NI+1)+1, 127, 1'b1);
    end
    wr(B, 127, 1'b1);
    do_run(127, 127, 127, -1, 0, -1, 0, -1);
    wr(B, 0, 1'b1);
    wr(B+NH, -128, 1'b1);
    do_run(127, 127, -128, -1, 0, -1, 0, -1);

    // Negative hidden pre-activation
    clear_all();
    wr(0, 16, 1'b1);
    wr(B, 16, 1'b1);
`ifdef MLP_LEAKY_RELU_EN
    leaky_lit = -8;
`else
    leaky_lit = 0;
`endif
    do_run(-64, 0, leaky_lit, -1, 0, -1, 0, -1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
